// File: rtl/cnn_layer_accel_awe_stride_picker_2d.sv
// Strided 2-D sample picker: keeps every S-th column of every S-th row from a
// raster stream of multi-lane beats, flagging the last kept column of each row.
module cnn_layer_accel_awe_stride_picker_2d #(
    parameter int C_DATA_WIDTH  = 16,
    parameter int C_NUM_LANES   = 4,
    parameter int C_MAX_STRIDE  = 8,
    parameter int C_MAX_ROW_LEN = 1024,
    localparam int CW = $clog2(C_MAX_STRIDE + 1),
    localparam int RW = $clog2(C_MAX_ROW_LEN + 1),
    localparam int DW = C_NUM_LANES * C_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          config_valid,
    input  logic [CW-1:0] stride_size,
    input  logic [RW-1:0] row_len,
    input  logic [DW-1:0] datain,
    input  logic          datain_valid,
    output logic          datain_ready,
    output logic [DW-1:0] dataout,
    output logic          dataout_valid,
    input  logic          dataout_ready,
    output logic          dataout_last
);

    localparam int SUMW = ((CW > RW) ? CW : RW) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] s_reg;
    logic [CW-1:0] s_cfg;
    logic [CW-1:0] col_phase;
    logic [CW-1:0] row_phase;
    logic [RW-1:0] l_reg;
    logic [RW-1:0] l_cfg;
    logic [RW-1:0] col_cnt;
    logic [SUMW-1:0] col_reach;
    logic          accept;
    logic          keep;
    logic          col_wrap;
    logic          col_phase_wrap;
    logic          row_phase_wrap;
    logic          last_col;

    // Zero means "no decimation"; oversize requests saturate at the build limits.
    always_comb begin
        s_cfg = stride_size;
        if (stride_size == '0) begin
            s_cfg = CW'(1);
        end else if (stride_size > CW'(C_MAX_STRIDE)) begin
            s_cfg = CW'(C_MAX_STRIDE);
        end
        l_cfg = row_len;
        if (row_len == '0) begin
            l_cfg = RW'(1);
        end else if (row_len > RW'(C_MAX_ROW_LEN)) begin
            l_cfg = RW'(C_MAX_ROW_LEN);
        end
    end

    always_comb begin
        state_next   = state;
        datain_ready = 1'b0;
        if (config_valid) begin
            state_next = RUN;
        end
        if (state == RUN) begin
            datain_ready = !dataout_valid || dataout_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A beat arriving alongside a reconfiguration is swallowed, not counted.
    assign accept         = datain_valid && datain_ready && !config_valid;
    assign keep           = (col_phase == '0) && (row_phase == '0);
    assign col_wrap       = (col_cnt == l_reg - RW'(1));
    assign col_phase_wrap = (col_phase == s_reg - CW'(1));
    assign row_phase_wrap = (row_phase == s_reg - CW'(1));
    assign col_reach      = SUMW'(col_cnt) + SUMW'(s_reg);
    assign last_col       = (col_reach >= SUMW'(l_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg     <= CW'(1);
            l_reg     <= RW'(1);
            col_cnt   <= '0;
            col_phase <= '0;
            row_phase <= '0;
        end else if (config_valid) begin
            s_reg     <= s_cfg;
            l_reg     <= l_cfg;
            col_cnt   <= '0;
            col_phase <= '0;
            row_phase <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col_cnt   <= '0;
                col_phase <= '0;
                row_phase <= row_phase_wrap ? '0 : row_phase + CW'(1);
            end else begin
                col_cnt   <= col_cnt + RW'(1);
                col_phase <= col_phase_wrap ? '0 : col_phase + CW'(1);
            end
        end
    end

    // Output register is independent of config so a held beat survives reconfiguration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout       <= '0;
            dataout_last  <= 1'b0;
            dataout_valid <= 1'b0;
        end else if (accept && keep) begin
            dataout       <= datain;
            dataout_last  <= last_col;
            dataout_valid <= 1'b1;
        end else if (dataout_ready) begin
            dataout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_awe_stride_picker_2d.sv
// Scoreboard bench for the stride picker: an index-based reference model
// predicts kept beats and last flags as inputs are accepted.
module tb_cnn_layer_accel_awe_stride_picker_2d;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int DW = W * N;
    localparam int CW = 4;
    localparam int RW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          config_valid;
    logic [CW-1:0] stride_size;
    logic [RW-1:0] row_len;
    logic [DW-1:0] datain;
    logic          datain_valid;
    logic          datain_ready;
    logic [DW-1:0] dataout;
    logic          dataout_valid;
    logic          dataout_ready;
    logic          dataout_last;

    int vectors     = 0;
    int miscompares = 0;
    int cur_s       = 1;
    int cur_l       = 1;
    int beat_idx    = 0;
    int out_count   = 0;
    logic [DW:0] sb[$];

    cnn_layer_accel_awe_stride_picker_2d dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .config_valid  (config_valid),
        .stride_size   (stride_size),
        .row_len       (row_len),
        .datain        (datain),
        .datain_valid  (datain_valid),
        .datain_ready  (datain_ready),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .dataout_ready (dataout_ready),
        .dataout_last  (dataout_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int v);
        logic [DW-1:0] d;
        for (int i = 0; i < N; i++) begin
            d[i*W +: W] = W'(v + i * 4096);
        end
        return d;
    endfunction

    function void model_cfg(input int s, input int l);
        cur_s    = (s == 0) ? 1 : ((s > 8) ? 8 : s);
        cur_l    = (l == 0) ? 1 : ((l > 1024) ? 1024 : l);
        beat_idx = 0;
    endfunction

    // Kept iff column and row indices are both multiples of the stride.
    function void model_push(input logic [DW-1:0] d);
        int   col;
        int   row;
        logic last_b;
        col    = beat_idx % cur_l;
        row    = beat_idx / cur_l;
        last_b = (col + cur_s >= cur_l);
        if ((col % cur_s == 0) && (row % cur_s == 0)) begin
            sb.push_back({last_b, d});
        end
        beat_idx++;
    endfunction

    task configure(input int s, input int l);
        @(posedge clk);
        #1;
        config_valid  = 1'b1;
        stride_size   = CW'(s);
        row_len       = RW'(l);
        datain_valid  = 1'b0;
        dataout_ready = 1'b1;
        @(posedge clk);
        #1;
        config_valid = 1'b0;
        model_cfg(s, l);
    endtask

    // ready_mode 0: dataout_ready held high; 1: toggles 1,0,1,0...
    task run_stream(input string name, input int n, input int base, input int ready_mode);
        int sent;
        int cyc;
        sent      = 0;
        cyc       = 0;
        out_count = 0;
        while ((sent < n || sb.size() != 0 || dataout_valid) && cyc < 400) begin
            @(posedge clk);
            #1;
            datain_valid  = (sent < n);
            datain        = mk(base + sent);
            dataout_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            @(negedge clk);
            if (datain_valid && datain_ready) begin
                model_push(datain);
                sent++;
            end
            if (dataout_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL %s unexpected beat: dataout=%h, expected no output", name, dataout);
                end else begin
                    if (dataout !== sb[0][DW-1:0] || dataout_last !== sb[0][DW]) begin
                        miscompares++;
                        $display("[TB] FAIL %s: dataout=%h last=%b, expected %h last=%b",
                                 name, dataout, dataout_last, sb[0][DW-1:0], sb[0][DW]);
                    end
                    if (dataout_ready) begin
                        void'(sb.pop_front());
                        out_count++;
                    end
                end
            end
            cyc++;
        end
        datain_valid = 1'b0;
        if (cyc >= 400) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s timeout: sent=%0d pending=%0d, expected all drained", name, sent, sb.size());
            sb.delete();
        end
    endtask

    task test_reset();
        rst_n         = 1'b0;
        config_valid  = 1'b0;
        stride_size   = '0;
        row_len       = '0;
        datain        = '0;
        datain_valid  = 1'b0;
        dataout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dataout_valid !== 1'b0 || datain_ready !== 1'b0 || dataout !== '0 || dataout_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: valid=%b ready=%b data=%h last=%b, expected all 0",
                     dataout_valid, datain_ready, dataout, dataout_last);
        end
        rst_n        = 1'b1;
        datain_valid = 1'b1;
        datain       = mk(7);
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (datain_ready !== 1'b0 || dataout_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_block: ready=%b valid=%b, expected 0 0", datain_ready, dataout_valid);
            end
        end
        datain_valid = 1'b0;
    endtask

    task test_stride2();
        configure(2, 4);
        run_stream("stride2", 16, 0, 0);
        vectors++;
        if (out_count !== 4) begin
            miscompares++;
            $display("[TB] FAIL stride2_count: got %0d, expected 4", out_count);
        end
    endtask

    task test_stride3();
        configure(3, 5);
        run_stream("stride3", 15, 0, 0);
        vectors++;
        if (out_count !== 2) begin
            miscompares++;
            $display("[TB] FAIL stride3_count: got %0d, expected 2", out_count);
        end
    endtask

    task test_backpressure();
        configure(1, 3);
        run_stream("backpressure", 6, 32, 1);
        vectors++;
        if (out_count !== 6) begin
            miscompares++;
            $display("[TB] FAIL backpressure_count: got %0d, expected 6", out_count);
        end
    endtask

    task test_zero_cfg();
        configure(0, 0);
        run_stream("zero_cfg", 5, 64, 0);
        vectors++;
        if (out_count !== 5) begin
            miscompares++;
            $display("[TB] FAIL zero_cfg_count: got %0d, expected 5", out_count);
        end
    endtask

    task test_clip();
        configure(15, 20);
        run_stream("clip", 40, 0, 0);
        vectors++;
        if (out_count !== 3) begin
            miscompares++;
            $display("[TB] FAIL clip_count: got %0d, expected 3", out_count);
        end
    endtask

    task test_cfg_coincident();
        configure(1, 4);
        @(posedge clk);
        #1;
        datain_valid  = 1'b1;
        datain        = mk(100);
        dataout_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (datain_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL coincident_accept: ready=%b, expected 1", datain_ready);
        end
        model_push(datain);
        @(posedge clk);
        #1;
        datain_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (dataout_valid !== 1'b1 || dataout !== sb[0][DW-1:0] || dataout_last !== sb[0][DW]) begin
            miscompares++;
            $display("[TB] FAIL coincident_hold: valid=%b data=%h last=%b, expected 1 %h %b",
                     dataout_valid, dataout, dataout_last, sb[0][DW-1:0], sb[0][DW]);
        end
        @(posedge clk);
        #1;
        config_valid  = 1'b1;
        stride_size   = CW'(2);
        row_len       = RW'(4);
        datain_valid  = 1'b1;
        datain        = mk(200);
        dataout_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (datain_ready !== 1'b1 || dataout_valid !== 1'b1 || dataout !== sb[0][DW-1:0]) begin
            miscompares++;
            $display("[TB] FAIL coincident_deliver: ready=%b valid=%b data=%h, expected 1 1 %h",
                     datain_ready, dataout_valid, dataout, sb[0][DW-1:0]);
        end
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        config_valid = 1'b0;
        datain_valid = 1'b0;
        model_cfg(2, 4);
        @(negedge clk);
        vectors++;
        if (dataout_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL coincident_discard: valid=%b data=%h, expected valid 0", dataout_valid, dataout);
        end
        run_stream("coincident_restart", 4, 0, 0);
        vectors++;
        if (out_count !== 2) begin
            miscompares++;
            $display("[TB] FAIL coincident_restart_count: got %0d, expected 2", out_count);
        end
    endtask

    task test_reset_midrow();
        configure(1, 4);
        @(posedge clk);
        #1;
        datain_valid  = 1'b1;
        datain        = mk(50);
        dataout_ready = 1'b0;
        @(posedge clk);
        #1;
        datain_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dataout_valid !== 1'b0 || datain_ready !== 1'b0 || dataout !== '0 || dataout_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrow_reset: valid=%b ready=%b data=%h last=%b, expected all 0",
                     dataout_valid, datain_ready, dataout, dataout_last);
        end
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        datain_valid  = 1'b1;
        dataout_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (datain_ready !== 1'b0 || dataout_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL post_reset_idle: ready=%b valid=%b, expected 0 0", datain_ready, dataout_valid);
            end
        end
        datain_valid = 1'b0;
        configure(1, 2);
        run_stream("after_reset", 4, 8, 0);
        vectors++;
        if (out_count !== 4) begin
            miscompares++;
            $display("[TB] FAIL after_reset_count: got %0d, expected 4", out_count);
        end
    endtask

    initial begin
        test_reset();
        test_stride2();
        test_stride3();
        test_backpressure();
        test_zero_cfg();
        test_clip();
        test_cfg_coincident();
        test_reset_midrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_awe_stride_picker_2d.md
CNN_LAYER_ACCEL_AWE_STRIDE_PICKER_2D -- requirements
Module: cnn_layer_accel_awe_stride_picker_2d

Interface
REQ-001 Parameter C_DATA_WIDTH, default 16: width of one lane sample.
REQ-002 Parameter C_NUM_LANES, default 4: parallel channels per beat, all sharing one valid and one decision.
REQ-003 Parameter C_MAX_STRIDE, default 8: largest supported stride; CW = $clog2(C_MAX_STRIDE+1).
REQ-004 Parameter C_MAX_ROW_LEN, default 1024: largest row length; RW = $clog2(C_MAX_ROW_LEN+1).
REQ-005 Port clk, input, 1: single clock; all state on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port config_valid, input, 1: one-cycle strobe loading stride_size and row_len.
REQ-008 Port stride_size, input, CW: keep every stride_size-th column and row.
REQ-009 Port row_len, input, RW: input samples per row.
REQ-010 Port datain, input, C_NUM_LANES*C_DATA_WIDTH: lane i at bits [i*W +: W].
REQ-011 Port datain_valid / datain_ready, input / output, 1 each: input handshake.
REQ-012 Port dataout, output, C_NUM_LANES*C_DATA_WIDTH: registered kept sample.
REQ-013 Port dataout_valid / dataout_ready, output / input, 1 each: output handshake.
REQ-014 Port dataout_last, output, 1: high with the last kept sample of a row.

Function
REQ-015 FSM states: IDLE (unconfigured) and RUN; reset enters IDLE; config_valid in any state enters RUN.
REQ-016 In IDLE, datain_ready SHALL be 0 and no beat is consumed.
REQ-017 On config_valid, latch S = max(stride_size,1) clipped to C_MAX_STRIDE and L = max(row_len,1) clipped to C_MAX_ROW_LEN; clear col_cnt, row_phase, col_phase to 0.
REQ-018 config_valid has priority over a simultaneous input accept; that beat is discarded (not counted, not output).
REQ-019 config_valid SHALL NOT disturb a beat already held in the output register.
REQ-020 In RUN, datain_ready = !dataout_valid || dataout_ready (single output register, no bubble under continuous ready).
REQ-021 A beat is accepted when datain_valid && datain_ready; only accepted beats advance counters.
REQ-022 Accepted beat is kept iff col_phase == 0 && row_phase == 0; kept beats load dataout/dataout_last and set dataout_valid next cycle (latency 1).
REQ-023 Dropped beats are consumed silently; dataout_valid falls on output handshake if no kept beat enters that cycle.
REQ-024 col_phase increments per accepted beat and wraps S-1 -> 0; col_cnt increments and wraps L-1 -> 0.
REQ-025 At col_cnt wrap: col_phase forced to 0, row_phase increments wrapping S-1 -> 0.
REQ-026 dataout_last = 1 for a kept beat whose column index c satisfies c + S >= L (last kept column of the row), including L not a multiple of S.
REQ-027 S = 1 passes every beat; dataout_last every L-th beat.
REQ-028 dataout, dataout_last SHALL hold stable while dataout_valid && !dataout_ready.

Reset
REQ-029 rst_n low asynchronously forces IDLE, dataout_valid = 0, dataout = 0, dataout_last = 0, datain_ready = 0, all counters 0, S = 1, L = 1.
REQ-030 Reset mid-row or with a pending output beat discards it; config_valid is required after rst_n rises.

Verification
REQ-031 S=2, L=4, 16 beats values 0..15, ready=1 -> outputs 0,2,8,10; last on 2 and 10.
REQ-032 S=3, L=5, 15 beats 0..14 -> outputs 0,3; last on 3; rows 1,2 dropped.
REQ-033 S=1, L=3, 6 beats, dataout_ready toggling 1,0 -> all 6 out in order, no loss/duplication, data stable while stalled.
REQ-034 stride_size=0, row_len=0 -> behaves as S=1, L=1; every beat output with last=1.
REQ-035 config_valid coincident with accepted beat while output held -> held beat delivered intact, coincident beat discarded, counters restart at 0.
REQ-036 rst_n low mid-row with dataout_valid=1 -> dataout_valid 0 immediately, datain_ready 0 until next config_valid.
